// File: rtl/dac_spi.sv
// rtl/dac_spi.sv - LTC2624 quad DAC SPI transmitter, 32-bit MSB-first frame with CS framing
module dac_spi #(
    parameter int HALF_PERIOD = 2
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic [11:0] data,
    input  logic [3:0]  address,
    input  logic [3:0]  command,
    input  logic        dactrig,
    output logic        dacdone,
    output logic        busy,
    output logic        spi_mosi,
    output logic        spi_sck,
    output logic        dac_cs,
    output logic        dac_clr
);

    // A one-cycle half period still needs a 1-bit counter to keep the vector legal.
    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

    state_t         state, state_n;
    logic [31:0]    shreg, shreg_n;
    logic [4:0]     bitcnt, bitcnt_n;
    logic [CW-1:0]  hcnt, hcnt_n;
    logic           sck_n, cs_n, done_n, busy_n;
    logic           hp_end;
    logic [31:0]    frame;

    assign frame    = {8'h00, command, address, data, 4'h0};
    assign hp_end   = (hcnt == HP_LAST);
    // MOSI is taken straight from the shift register's top flop.
    assign spi_mosi = shreg[31];

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            shreg   <= 32'h0;
            bitcnt  <= 5'd0;
            hcnt    <= '0;
            spi_sck <= 1'b0;
            dac_cs  <= 1'b1;
            dacdone <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bitcnt  <= bitcnt_n;
            hcnt    <= hcnt_n;
            spi_sck <= sck_n;
            dac_cs  <= cs_n;
            dacdone <= done_n;
            busy    <= busy_n;
        end
    end

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) dac_clr <= 1'b0;
        else     dac_clr <= 1'b1;
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        hcnt_n   = hcnt;
        sck_n    = spi_sck;
        cs_n     = dac_cs;
        done_n   = dacdone;
        busy_n   = busy;
        case (state)
            IDLE: begin
                if (dactrig) begin
                    shreg_n  = frame;
                    cs_n     = 1'b0;
                    busy_n   = 1'b1;
                    bitcnt_n = 5'd0;
                    hcnt_n   = '0;
                    sck_n    = 1'b0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (hp_end) begin
                    hcnt_n = '0;
                    if (!spi_sck) begin
                        sck_n = 1'b1;
                    end else begin
                        sck_n = 1'b0;
                        // Bit 31 stays on MOSI through HOLD.
                        if (bitcnt == 5'd31) begin
                            state_n = HOLD;
                        end else begin
                            bitcnt_n = bitcnt + 5'd1;
                            shreg_n  = {shreg[30:0], 1'b0};
                        end
                    end
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            HOLD: begin
                if (hp_end) begin
                    hcnt_n  = '0;
                    cs_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            DONE: begin
                done_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dac_spi.sv
// tb/tb_dac_spi.sv - directed bench for dac_spi with a bit-bang capture model
module tb_dac_spi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] d0 = '0, d1 = '0;
    logic [3:0]  a0 = '0, a1 = '0, c0 = '0, c1 = '0;
    logic        t0 = 1'b0, t1 = 1'b0;
    logic        done0, busy0, mosi0, sck0, cs0, clr0;
    logic        done1, busy1, mosi1, sck1, cs1, clr1;

    int tests_run = 0;
    int tests_failed = 0;

    always #10 clk = ~clk;

    dac_spi #(.HALF_PERIOD(2)) dut0 (
        .CLK50MHZ(clk), .RST(rst), .data(d0), .address(a0), .command(c0),
        .dactrig(t0), .dacdone(done0), .busy(busy0), .spi_mosi(mosi0),
        .spi_sck(sck0), .dac_cs(cs0), .dac_clr(clr0)
    );

    dac_spi #(.HALF_PERIOD(1)) dut1 (
        .CLK50MHZ(clk), .RST(rst), .data(d1), .address(a1), .command(c1),
        .dactrig(t1), .dacdone(done1), .busy(busy1), .spi_mosi(mosi1),
        .spi_sck(sck1), .dac_cs(cs1), .dac_clr(clr1)
    );

    logic cs_w[2], sck_w[2], mosi_w[2], done_w[2], busy_w[2];
    assign cs_w[0] = cs0;     assign cs_w[1] = cs1;
    assign sck_w[0] = sck0;   assign sck_w[1] = sck1;
    assign mosi_w[0] = mosi0; assign mosi_w[1] = mosi1;
    assign done_w[0] = done0; assign done_w[1] = done1;
    assign busy_w[0] = busy0; assign busy_w[1] = busy1;

    // Bit-bang capture: sample MOSI on every observed SCK rise while CS is low.
    int          ncyc = 0;
    int          frames[2], gap[2], hi_cnt[2], rises[2], last_rises[2];
    int          done_cnt[2], acc_cyc[2], first_rise[2], last_rise[2];
    logic [31:0] acc[2], last_frame[2];
    logic        pcs[2] = '{1'b1, 1'b1};
    logic        psck[2] = '{1'b0, 1'b0};

    initial begin
        for (int k = 0; k < 2; k++) begin
            frames[k] = 0; gap[k] = 0; hi_cnt[k] = 0; rises[k] = 0; last_rises[k] = 0;
            done_cnt[k] = 0; acc_cyc[k] = 0; first_rise[k] = 0; last_rise[k] = 0;
            acc[k] = '0; last_frame[k] = '0;
        end
    end

    always @(negedge clk) begin
        ncyc++;
        for (int k = 0; k < 2; k++) begin
            if (done_w[k]) done_cnt[k]++;
            if (!cs_w[k]) begin
                if (pcs[k]) begin
                    frames[k]++;
                    gap[k] = hi_cnt[k];
                    hi_cnt[k] = 0;
                    acc[k] = '0;
                    rises[k] = 0;
                    acc_cyc[k] = ncyc;
                end
                if (sck_w[k] && !psck[k]) begin
                    acc[k] = {acc[k][30:0], mosi_w[k]};
                    if (rises[k] == 0) first_rise[k] = ncyc;
                    last_rise[k] = ncyc;
                    rises[k]++;
                end
            end else begin
                hi_cnt[k]++;
                if (!pcs[k]) begin
                    last_frame[k] = acc[k];
                    last_rises[k] = rises[k];
                end
            end
            pcs[k] = cs_w[k];
            psck[k] = sck_w[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic set_trig(input int k, input logic v);
        if (k == 0) t0 = v;
        else        t1 = v;
    endtask

    // n returns the number of edges from the accepting edge to the dacdone edge.
    task automatic run_frame(input int k, input logic [11:0] d, input logic [3:0] a,
                             input logic [3:0] c, input int hold, input bit disturb,
                             output int n);
        if (k == 0) begin d0 = d; a0 = a; c0 = c; end
        else        begin d1 = d; a1 = a; c1 = c; end
        set_trig(k, 1'b1);
        n = 0;
        tick;
        check("accept cs low", {31'b0, cs_w[k]}, 32'd0);
        check("accept busy", {31'b0, busy_w[k]}, 32'd1);
        while (!done_w[k] && n < 400) begin
            if (n >= hold - 1) set_trig(k, 1'b0);
            if (disturb && n == 40) begin
                d0 = 12'hFFF;
                set_trig(k, 1'b1);
            end
            if (disturb && n == 41)
                check("inflight busy", {31'b0, busy0}, 32'd1);
            tick;
            n++;
        end
    endtask

    initial begin
        int n, dc;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, dc;

        repeat (3) tick;
        check("rst cs", {31'b0, cs0}, 32'd1);
        check("rst sck", {31'b0, sck0}, 32'd0);
        check("rst mosi", {31'b0, mosi0}, 32'd0);
        check("rst clr", {31'b0, clr0}, 32'd0);
        check("rst done", {31'b0, done0}, 32'd0);
        check("rst busy", {31'b0, busy0}, 32'd0);
        rst = 1'b0;
        #1;
        check("clr before edge", {31'b0, clr0}, 32'd0);
        tick;
        check("clr after edge", {31'b0, clr0}, 32'd1);

        // Single frame, with data change and retrigger mid-flight.
        run_frame(0, 12'h5F3, 4'h0, 4'h3, 2, 1'b1, n);
        check("single done edge", n, 32'd130);
        check("single frame", last_frame[0], 32'h00305F30);
        check("single rises", last_rises[0], 32'd32);
        check("single cs to sck", first_rise[0] - acc_cyc[0], 32'd2);
        check("single sck span", last_rise[0] - first_rise[0], 32'd124);
        check("single busy at done", {31'b0, busy0}, 32'd1);
        tick;
        check("done pulse width", {31'b0, done0}, 32'd0);
        check("busy after done", {31'b0, busy0}, 32'd0);
        repeat (20) tick;
        check("single frame count", frames[0], 32'd1);
        check("single done count", done_cnt[0], 32'd1);

        // Second frame after a pulsed request.
        run_frame(0, 12'h3F5, 4'h0, 4'h3, 1, 1'b0, n);
        check("second done edge", n, 32'd130);
        check("second frame", last_frame[0], 32'h00303F50);
        check("second cs gap", {31'b0, gap[0] >= 2}, 32'd1);
        repeat (5) tick;

        // dactrig held through dacdone: repeat frame with minimum CS-high gap.
        run_frame(0, 12'h3F5, 4'h0, 4'h3, 1000, 1'b0, n);
        check("held done edge", n, 32'd130);
        tick;
        check("held busy drop", {31'b0, busy0}, 32'd0);
        check("held cs high", {31'b0, cs0}, 32'd1);
        tick;
        set_trig(0, 1'b0);
        check("repeat cs low", {31'b0, cs0}, 32'd0);
        check("repeat cs gap", gap[0], 32'd2);
        n = 0;
        while (!done0 && n < 400) begin
            tick;
            n++;
        end
        check("repeat done edge", n, 32'd130);
        check("repeat frame", last_frame[0], 32'h00303F50);
        check("frame count", frames[0], 32'd4);
        repeat (5) tick;

        // Reset mid-frame after bit 10.
        d0 = 12'h123; a0 = 4'h1; c0 = 4'h3;
        set_trig(0, 1'b1);
        tick;
        set_trig(0, 1'b0);
        n = 0;
        while (rises[0] < 11 && n < 200) begin
            tick;
            n++;
        end
        check("abort reached bit 10", rises[0], 32'd11);
        rst = 1'b1;
        #1;
        check("abort cs", {31'b0, cs0}, 32'd1);
        check("abort sck", {31'b0, sck0}, 32'd0);
        check("abort busy", {31'b0, busy0}, 32'd0);
        check("abort clr", {31'b0, clr0}, 32'd0);
        dc = done_cnt[0];
        repeat (4) tick;
        rst = 1'b0;
        tick;
        check("abort no done", done_cnt[0], dc);
        run_frame(0, 12'h123, 4'h1, 4'h3, 2, 1'b0, n);
        check("post-abort done edge", n, 32'd130);
        check("post-abort frame", last_frame[0], 32'h00311230);
        check("post-abort rises", last_rises[0], 32'd32);
        repeat (3) tick;

        // Fastest SCK.
        run_frame(1, 12'h000, 4'hF, 4'h3, 1, 1'b0, n);
        check("fast done edge", n, 32'd65);
        check("fast frame", last_frame[1], 32'h003F0000);
        check("fast rises", last_rises[1], 32'd32);
        check("fast cs to sck", first_rise[1] - acc_cyc[1], 32'd1);
        check("fast sck span", last_rise[1] - first_rise[1], 32'd62);
        tick;
        check("fast busy drop", {31'b0, busy1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
